// File: rtl/wiring_sequencer.sv
// Transaction controller for a Wiring netlist: pulses logic_reset, applies one input
// vector for a cycle, waits for wiring_running to stay quiet (or a timeout), returns out.
module wiring_sequencer #(
  parameter int unsigned INPUT_WIDTH   = 2,
  parameter int unsigned OUTPUT_WIDTH  = 1,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_in,
  output logic                    wiring_logic_reset,
  output logic [INPUT_WIDTH-1:0]  wiring_in,
  input  logic                    wiring_running,
  input  logic [OUTPUT_WIDTH-1:0] wiring_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [OUTPUT_WIDTH-1:0] resp_out,
  output logic                    resp_timeout,
  output logic [15:0]             resp_cycles,
  output logic                    busy,
  output logic [7:0]              timeout_count
);

  localparam logic [7:0]  SettleCnt  = 8'(SETTLE_CYCLES);
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLrst, StDrive, StSettle, StResp} state_e;

  state_e                  state_q, state_d;
  logic [INPUT_WIDTH-1:0]  vec_q, vec_d;
  logic [7:0]              quiet_q, quiet_d, quiet_nxt;
  logic [15:0]             elapsed_q, elapsed_d, elapsed_nxt;
  logic [OUTPUT_WIDTH-1:0] resp_out_q, resp_out_d;
  logic                    resp_timeout_q, resp_timeout_d;
  logic [15:0]             resp_cycles_q, resp_cycles_d;
  logic [7:0]              timeout_count_q, timeout_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      vec_q           <= '0;
      quiet_q         <= '0;
      elapsed_q       <= '0;
      resp_out_q      <= '0;
      resp_timeout_q  <= 1'b0;
      resp_cycles_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      vec_q           <= vec_d;
      quiet_q         <= quiet_d;
      elapsed_q       <= elapsed_d;
      resp_out_q      <= resp_out_d;
      resp_timeout_q  <= resp_timeout_d;
      resp_cycles_q   <= resp_cycles_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    vec_d           = vec_q;
    quiet_d         = quiet_q;
    elapsed_d       = elapsed_q;
    resp_out_d      = resp_out_q;
    resp_timeout_d  = resp_timeout_q;
    resp_cycles_d   = resp_cycles_q;
    timeout_count_d = timeout_count_q;
    quiet_nxt       = wiring_running ? 8'd0 : quiet_q + 8'd1;
    elapsed_nxt     = elapsed_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          vec_d     = req_in;
          quiet_d   = '0;
          elapsed_d = '0;
          state_d   = StLrst;
        end
      end
      StLrst:  state_d = StDrive;
      StDrive: state_d = StSettle;
      StSettle: begin
        quiet_d   = quiet_nxt;
        elapsed_d = elapsed_nxt;
        // Settle takes priority when both conditions land on the same edge.
        if (quiet_nxt == SettleCnt) begin
          resp_out_d     = wiring_out;
          resp_timeout_d = 1'b0;
          resp_cycles_d  = elapsed_nxt;
          state_d        = StResp;
        end else if (elapsed_nxt == TimeoutCnt) begin
          resp_out_d     = wiring_out;
          resp_timeout_d = 1'b1;
          resp_cycles_d  = TimeoutCnt;
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
          state_d        = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready          = (state_q == StIdle);
  assign wiring_logic_reset = (state_q == StLrst);
  assign wiring_in          = (state_q == StDrive) ? vec_q : '0;
  assign resp_valid         = (state_q == StResp);
  assign busy               = (state_q != StIdle);
  assign resp_out           = resp_out_q;
  assign resp_timeout       = resp_timeout_q;
  assign resp_cycles        = resp_cycles_q;
  assign timeout_count      = timeout_count_q;

endmodule

// File: tb/tb_wiring_sequencer.sv
// Directed bench for wiring_sequencer with a behavioural AND-gate Wiring model.
module tb_wiring_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_in = '0;
  logic       wiring_logic_reset;
  logic [1:0] wiring_in;
  logic       wiring_running;
  logic [0:0] wiring_out;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [0:0] resp_out;
  logic       resp_timeout;
  logic [15:0] resp_cycles;
  logic       busy;
  logic [7:0] timeout_count;

  int checks = 0;
  int errors = 0;
  int exp_tc = 0;
  int run_mode = 0;  // 0: never running, 1: running for 3 SETTLE cycles, 2: stuck high
  int since_lrst = 0;
  logic mout = 1'b0;

  always #5 clk = ~clk;

  wiring_sequencer #(
    .INPUT_WIDTH(2), .OUTPUT_WIDTH(1), .SETTLE_CYCLES(2), .TIMEOUT(10)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
    .wiring_logic_reset(wiring_logic_reset), .wiring_in(wiring_in),
    .wiring_running(wiring_running), .wiring_out(wiring_out), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_out(resp_out), .resp_timeout(resp_timeout),
    .resp_cycles(resp_cycles), .busy(busy), .timeout_count(timeout_count)
  );

  // Wiring model: 2-input AND latched on the drive cycle, cleared by logic_reset.
  always @(posedge clk) begin
    if (wiring_logic_reset) begin
      mout       <= 1'b0;
      since_lrst <= 0;
    end else begin
      if (wiring_in != 2'b00) mout <= &wiring_in;
      since_lrst <= since_lrst + 1;
    end
  end
  assign wiring_out = mout;
  assign wiring_running = (run_mode == 2) ? 1'b1 :
                          (run_mode == 1) ? (since_lrst >= 1 && since_lrst <= 3) : 1'b0;

  typedef struct {
    logic [1:0] vin;
    int         mode;
    logic       eout;
    logic       eto;
    int         ecyc;
    int         elat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] v, input int mode, input logic eout, input logic eto,
                         input int ecyc, input int elat, input bit hold);
    int lat;
    bit got;
    run_mode   = mode;
    resp_ready = !hold;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_in    = v;
    @(posedge clk);  // edge T
    @(negedge clk);
    req_valid = 1'b0;
    chk("lrst_pulse", {31'b0, wiring_logic_reset}, 32'd1);
    chk("lrst_in_zero", {30'b0, wiring_in}, 32'd0);
    @(negedge clk);
    chk("drive_in", {30'b0, wiring_in}, {30'b0, v});
    chk("drive_lrst_low", {31'b0, wiring_logic_reset}, 32'd0);
    lat = 2;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL resp_wait: got no resp_valid expected within 400 cycles");
      resp_ready = 1'b1;
      return;
    end
    if (eto && exp_tc < 255) exp_tc++;
    chk("latency", lat, elat);
    chk("resp_out", {31'b0, resp_out}, {31'b0, eout});
    chk("resp_timeout", {31'b0, resp_timeout}, {31'b0, eto});
    chk("resp_cycles", {16'b0, resp_cycles}, ecyc);
    chk("timeout_count", {24'b0, timeout_count}, exp_tc);
    if (hold) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'b0, resp_valid}, 32'd1);
        chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        chk("hold_out", {31'b0, resp_out}, {31'b0, eout});
        chk("hold_cycles", {16'b0, resp_cycles}, ecyc);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk("back_idle_busy", {31'b0, busy}, 32'd0);
    chk("back_idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{2'b11, 0, 1'b1, 1'b0, 2, 5};
    tbl[1] = '{2'b01, 0, 1'b0, 1'b0, 2, 5};
    tbl[2] = '{2'b10, 1, 1'b0, 1'b0, 5, 8};
    tbl[3] = '{2'b11, 1, 1'b1, 1'b0, 5, 8};
    tbl[4] = '{2'b11, 2, 1'b1, 1'b1, 10, 13};
    tbl[5] = '{2'b00, 0, 1'b0, 1'b0, 2, 5};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_lrst", {31'b0, wiring_logic_reset}, 32'd0);
    chk("rst_wiring_in", {30'b0, wiring_in}, 32'd0);
    chk("rst_tc", {24'b0, timeout_count}, 32'd0);

    foreach (tbl[i])
      run_txn(tbl[i].vin, tbl[i].mode, tbl[i].eout, tbl[i].eto, tbl[i].ecyc, tbl[i].elat, 1'b0);

    // Backpressure on the response channel
    run_txn(2'b01, 0, 1'b0, 1'b0, 2, 5, 1'b1);

    // Timeout counter saturation
    for (int i = 0; i < 260; i++) run_txn(2'b01, 2, 1'b0, 1'b1, 10, 13, 1'b0);
    chk("tc_saturated", {24'b0, timeout_count}, 32'd255);

    // Reset in the middle of SETTLE
    run_mode = 2;
    @(negedge clk);
    req_valid = 1'b1;
    req_in    = 2'b11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_tc = 0;
    chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_tc", {24'b0, timeout_count}, 32'd0);
    chk("mid_rst_cycles", {16'b0, resp_cycles}, 32'd0);
    chk("mid_rst_lrst", {31'b0, wiring_logic_reset}, 32'd0);
    run_txn(2'b11, 0, 1'b1, 1'b0, 2, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
